// File: rtl/matrix_pkg.sv
// matrix_pkg: shared symbol/state types, matrix geometry, glyph table and arbitration rule
package matrix_pkg;
  typedef enum logic [1:0] {ZERO = 2'd0, A = 2'd1, G = 2'd2} sym_t;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_st_t;
  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;
  localparam logic [NUM_ROWS-1:0] GLYPH [3][NUM_COLS] = '{
    '{7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E},
    '{7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E},
    '{7'h3E, 7'h41, 7'h49, 7'h49, 7'h7A}
  };
  // A tie hands the grant to whichever requester did not win last time
  function automatic sym_t arbitrate(logic req_a, logic req_g, sym_t last);
    return req_a && req_g ? (last == A ? G : A) : req_a ? A : req_g ? G : ZERO;
  endfunction
endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// matrix_scan_ctrl_if: enable/request inputs and column/row drive outputs of the scan controller
interface matrix_scan_ctrl_if;
  logic en;
  logic as;
  logic gt;
  logic [matrix_pkg::NUM_COLS-1:0] c;
  logic [matrix_pkg::NUM_ROWS-1:0] l;
  matrix_pkg::sym_t sym;
  logic frame_done;
  modport master(output en, as, gt, input c, l, sym, frame_done);
  modport slave(input en, as, gt, output c, l, sym, frame_done);
endinterface

// File: rtl/matrix_glyph_rom.sv
// matrix_glyph_rom: combinational glyph lookup, dark for illegal symbol codes or columns
module matrix_glyph_rom
  import matrix_pkg::*;
(
  input  sym_t                sym,
  input  logic [2:0]          col,
  output logic [NUM_ROWS-1:0] rows
);
  always_comb rows = (sym inside {ZERO, A, G}) && col < 3'(NUM_COLS) ? GLYPH[sym][col] : '0;
endmodule

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: one-hot column scan with blanking gap and frame-synchronous round-robin symbol select
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int PRESCALE  = 4,
  parameter int BLANK_CYC = 1,
  parameter int CNT_W     = 8
) (
  input logic clk,
  input logic rst_n,
  matrix_scan_ctrl_if.slave bus
);
  localparam scan_st_t FIRST = BLANK_CYC == 0 ? SHOW : BLANK;
  localparam logic [CNT_W-1:0] SHOW_END = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC > 0 ? BLANK_CYC - 1 : 0);
  localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);
  scan_st_t state, state_n;
  logic [2:0] col, col_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  sym_t sym, sym_n, last_grant, last_grant_n;
  logic start;
  logic [NUM_ROWS-1:0] rows;
  matrix_glyph_rom u_rom (.sym(sym_n), .col(col_n), .rows(rows));
  assign bus.sym = sym;
  always_comb begin
    state_n = state;
    col_n = col;
    cnt_n = cnt;
    sym_n = sym;
    last_grant_n = last_grant;
    start = 1'b0;
    if (!bus.en) begin
      state_n = IDLE;
      col_n = '0;
      cnt_n = '0;
    end else begin
      unique case (state)
        IDLE: start = 1'b1;
        BLANK: begin
          state_n = cnt == BLANK_END ? SHOW : BLANK;
          cnt_n = cnt == BLANK_END ? '0 : cnt + 1'b1;
        end
        SHOW:
          if (cnt != SHOW_END) cnt_n = cnt + 1'b1;
          else if (col == LAST_COL) start = 1'b1;
          else begin
            col_n = col + 1'b1;
            cnt_n = '0;
            state_n = FIRST;
          end
        default: state_n = IDLE;
      endcase
      if (start) begin
        state_n = FIRST;
        col_n = '0;
        cnt_n = '0;
        sym_n = arbitrate(bus.as, bus.gt, last_grant);
        last_grant_n = sym_n == ZERO ? last_grant : sym_n;
      end
    end
  end
  // Drive is derived from the next state so C, L and the state always move on the same edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      col <= '0;
      cnt <= '0;
      sym <= ZERO;
      last_grant <= G;
      bus.c <= '0;
      bus.l <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      state <= state_n;
      col <= col_n;
      cnt <= cnt_n;
      sym <= sym_n;
      last_grant <= last_grant_n;
      bus.c <= state_n == SHOW ? NUM_COLS'(1) << col_n : '0;
      bus.l <= state_n == SHOW ? rows : '0;
      bus.frame_done <= state_n == SHOW && col_n == LAST_COL && cnt_n == SHOW_END;
    end
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb_matrix_scan_ctrl: default and BLANK_CYC=0/PRESCALE=1 instances checked against a frame-position model
module tb_matrix_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, as_r = 1'b0, gt_r = 1'b0;
  int compared = 0, mismatched = 0;
  matrix_scan_ctrl_if bus0 ();
  matrix_scan_ctrl_if bus1 ();
  assign bus0.en = en;
  assign bus0.as = as_r;
  assign bus0.gt = gt_r;
  assign bus1.en = en;
  assign bus1.as = as_r;
  assign bus1.gt = gt_r;
  matrix_scan_ctrl #(.PRESCALE(4), .BLANK_CYC(1), .CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  matrix_scan_ctrl #(.PRESCALE(1), .BLANK_CYC(0), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  always #5 clk = ~clk;

  logic [14:0] obs [2];
  assign obs[0] = {bus0.c, bus0.l, bus0.sym, bus0.frame_done};
  assign obs[1] = {bus1.c, bus1.l, bus1.sym, bus1.frame_done};

  // Model: position t within a frame; column = t / period, lit when past the blanking part
  int bb [2] = '{1, 0};
  int pp [2] = '{4, 1};
  logic [6:0] gly [3][5] = '{'{7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E},
                             '{7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E},
                             '{7'h3E, 7'h41, 7'h49, 7'h49, 7'h7A}};
  int act [2], tt [2], msym [2], mlast [2];
  logic [14:0] e_vec [2];
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      int per, col;
      logic lit;
      per = bb[k] + pp[k];
      if (!rst_n) begin
        act[k] = 0; tt[k] = 0; msym[k] = 0; mlast[k] = 2;
      end else if (!en) act[k] = 0;
      else if (act[k] == 0 || tt[k] == 5 * per - 1) begin
        act[k] = 1;
        tt[k] = 0;
        msym[k] = (as_r && gt_r) ? (mlast[k] == 1 ? 2 : 1) : as_r ? 1 : gt_r ? 2 : 0;
        if (msym[k] != 0) mlast[k] = msym[k];
      end else tt[k]++;
      col = tt[k] / per;
      lit = act[k] != 0 && (tt[k] % per) >= bb[k];
      e_vec[k] = {lit ? 5'(1 << col) : 5'd0, lit ? gly[msym[k]][col] : 7'd0, 2'(msym[k]),
                  act[k] != 0 && tt[k] == 5 * per - 1};
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick;
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (obs[k] !== 15'd0) begin mismatched++; $display("FAIL reset dut%0d got %h want 0", k, obs[k]); end
    end
    rst_n = 1'b1;
    tick;
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (obs[k] !== 15'd0) begin mismatched++; $display("FAIL idle dut%0d got %h want 0", k, obs[k]); end
    end
  endtask

  task automatic test_zero_frame;
    int fd_cnt = 0;
    en = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick;
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== e_vec[k]) begin mismatched++; $display("FAIL zero_frame dut%0d cyc %0d got %h want %h", k, cyc, obs[k], e_vec[k]); end
      end
      if (cyc <= 25 && bus0.frame_done === 1'b1) fd_cnt++;
      if (cyc == 1) begin
        compared++;
        if (bus0.c !== 5'd0 || bus0.l !== 7'd0) begin mismatched++; $display("FAIL first_blank got c=%b l=%h want 0", bus0.c, bus0.l); end
      end
      if (cyc >= 2 && cyc <= 5) begin
        compared++;
        if (bus0.c !== 5'b00001 || bus0.l !== 7'h3E) begin mismatched++; $display("FAIL col1 cyc %0d got c=%b l=%h want 00001/3e", cyc, bus0.c, bus0.l); end
      end
      if (cyc == 25) begin
        compared++;
        if (bus0.frame_done !== 1'b1 || bus0.sym !== matrix_pkg::ZERO) begin mismatched++; $display("FAIL frame_done25 got fd=%b sym=%0d want 1/0", bus0.frame_done, bus0.sym); end
      end
      if (cyc <= 6) begin
        compared++;
        if (bus1.c !== 5'(1 << ((cyc - 1) % 5)) || bus1.frame_done !== (cyc == 5)) begin
          mismatched++; $display("FAIL fast_scan cyc %0d got c=%b fd=%b", cyc, bus1.c, bus1.frame_done);
        end
      end
    end
    compared++;
    if (fd_cnt != 1) begin mismatched++; $display("FAIL fd_count got %0d want 1", fd_cnt); end
  endtask

  task automatic test_a_frame;
    int n = 0;
    while (bus0.frame_done !== 1'b1 && n < 60) begin
      tick; n++;
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== e_vec[k]) begin mismatched++; $display("FAIL a_wait dut%0d got %h want %h", k, obs[k], e_vec[k]); end
      end
    end
    if (n >= 60) begin mismatched++; $display("FAIL a_wait timeout got no frame_done want pulse"); end
    as_r = 1'b1;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      tick;
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== e_vec[k]) begin mismatched++; $display("FAIL a_frame dut%0d cyc %0d got %h want %h", k, cyc, obs[k], e_vec[k]); end
      end
      if (bus0.c == 5'b00010) begin
        compared++;
        if (bus0.l !== 7'h11) begin mismatched++; $display("FAIL a_col2 got %h want 11", bus0.l); end
      end
      if (bus0.c == 5'b10000) begin
        compared++;
        if (bus0.l !== 7'h7E) begin mismatched++; $display("FAIL a_col5 got %h want 7e", bus0.l); end
      end
      if (cyc == 10) as_r = 1'b0;
      if (cyc == 25) begin
        compared++;
        if (bus0.frame_done !== 1'b1 || bus0.sym !== matrix_pkg::A) begin mismatched++; $display("FAIL a_hold got fd=%b sym=%0d want 1/1", bus0.frame_done, bus0.sym); end
      end
    end
    tick;
    compared++;
    if (bus0.sym !== matrix_pkg::ZERO) begin mismatched++; $display("FAIL a_release got sym=%0d want 0", bus0.sym); end
  endtask

  task automatic test_tie;
    int seq [5];
    int n = 0;
    while (bus0.frame_done !== 1'b1 && n < 60) begin tick; n++; end
    if (n >= 60) begin mismatched++; $display("FAIL tie_wait timeout got no frame_done want pulse"); end
    for (int f = 0; f < 5; f++) begin
      as_r = f != 3;
      gt_r = f != 3;
      n = 0;
      do begin
        tick; n++;
        for (int k = 0; k < 2; k++) begin
          compared++;
          if (obs[k] !== e_vec[k]) begin mismatched++; $display("FAIL tie dut%0d frame %0d got %h want %h", k, f, obs[k], e_vec[k]); end
        end
      end while (bus0.frame_done !== 1'b1 && n < 60);
      if (n >= 60) begin mismatched++; $display("FAIL tie_frame timeout frame %0d", f); end
      seq[f] = int'(bus0.sym);
    end
    compared++;
    if (!(seq[0] inside {1, 2}) || seq[1] != 3 - seq[0] || seq[2] != seq[0] || seq[3] != 0 || seq[4] != 3 - seq[2]) begin
      mismatched++; $display("FAIL tie_seq got %0d %0d %0d %0d %0d want alternating, 0, then opposite", seq[0], seq[1], seq[2], seq[3], seq[4]);
    end
    as_r = 1'b0;
    gt_r = 1'b0;
  endtask

  task automatic test_en_drop;
    int n = 0;
    while (bus0.c !== 5'b00100 && n < 60) begin tick; n++; end
    if (n >= 60) begin mismatched++; $display("FAIL en_wait timeout got no column 3 want it"); end
    en = 1'b0;
    tick;
    compared++;
    if (bus0.c !== 5'd0 || bus0.l !== 7'd0 || bus0.frame_done !== 1'b0) begin
      mismatched++; $display("FAIL en_drop got c=%b l=%h fd=%b want 0", bus0.c, bus0.l, bus0.frame_done);
    end
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc == 2) en = 1'b1;
      tick;
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== e_vec[k]) begin mismatched++; $display("FAIL en_restart dut%0d cyc %0d got %h want %h", k, cyc, obs[k], e_vec[k]); end
      end
      if (cyc == 2 || cyc == 3) begin
        compared++;
        if (bus0.c !== (cyc == 2 ? 5'b00000 : 5'b00001)) begin mismatched++; $display("FAIL en_restart_col cyc %0d got c=%b", cyc, bus0.c); end
      end
    end
  endtask

  task automatic test_async_reset;
    int n = 0;
    while (bus0.c === 5'd0 && n < 60) begin tick; n++; end
    if (n >= 60) begin mismatched++; $display("FAIL rst_wait timeout got no lit column"); end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (obs[k] !== 15'd0) begin mismatched++; $display("FAIL async_reset dut%0d got %h want 0", k, obs[k]); end
    end
    #3 rst_n = 1'b1;
    as_r = 1'b1;
    gt_r = 1'b1;
    tick;
    compared++;
    if (bus0.sym !== matrix_pkg::A || bus1.sym !== matrix_pkg::A) begin
      mismatched++; $display("FAIL first_tie got %0d/%0d want 1/1", bus0.sym, bus1.sym);
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick;
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== e_vec[k]) begin mismatched++; $display("FAIL post_reset dut%0d cyc %0d got %h want %h", k, cyc, obs[k], e_vec[k]); end
      end
    end
  endtask

  task automatic test_random;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      en = $urandom_range(0, 39) != 0;
      if ($urandom_range(0, 7) == 0) as_r = 1'($urandom);
      if ($urandom_range(0, 7) == 0) gt_r = 1'($urandom);
      tick;
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== e_vec[k]) begin mismatched++; $display("FAIL random dut%0d cyc %0d got %h want %h", k, cyc, obs[k], e_vec[k]); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_zero_frame;
    test_a_frame;
    test_tie;
    test_en_drop;
    test_async_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/matrix_scan_ctrl.md
Name: matrix_scan_ctrl

Overview:
- Scan controller for the 5-column x 7-row LED matrix: sequences one-hot column drive C1..C5 with per-column dwell and an anti-ghosting blanking gap.
- Arbitrates the symbol requesters AS ("A") and GT ("G") with frame-synchronous round-robin; default symbol is "0".
- Replaces the free-running flip-flop column counter; drives rows L1..L7 from a glyph ROM.

Parameters:
- PRESCALE, 4, clock cycles each column is lit (SHOW dwell); legal range >= 1.
- BLANK_CYC, 1, clock cycles of all-off before each column; 0 skips the BLANK state.
- CNT_W, 8, width of the internal dwell/blank counter; PRESCALE and BLANK_CYC must be < 2^CNT_W.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  scan enable; low forces the display dark.
- AS  in  1  request to display "A".
- GT  in  1  request to display "G".
- C  out  5  column drive, one-hot, active-high; C[0]=C1.
- L  out  7  row drive, active-high; L[0]=L1 (top row).
- SYM  out  2  symbol latched for the current frame: 0=ZERO, 1=A, 2=G.
- FRAME_DONE  out  1  one-cycle pulse in the last SHOW cycle of column 5.

Behaviour:
- Reset (async, RST_N=0): state=IDLE, col=0, cnt=0, SYM=ZERO, last_grant=G, C=0, L=0, FRAME_DONE=0.
- All outputs are registered. C and L change on the same edge and are never lit during IDLE or BLANK.
- IDLE:
  - C=0, L=0.
  - EN=1 causes a frame start: latch SYM, col=0, then go to BLANK (or to SHOW if BLANK_CYC=0).
- BLANK: C=0, L=0 for exactly BLANK_CYC cycles, then SHOW.
- SHOW:
  - C = 1<<col and L = glyph(SYM, col) for exactly PRESCALE cycles.
  - Columns 0..3: col++ then BLANK/SHOW.
  - Column 4: FRAME_DONE=1 in its last cycle. Next edge is a frame start: col wraps to 0 and SYM is re-latched.
- Column period = BLANK_CYC+PRESCALE. Frame period = 5*(BLANK_CYC+PRESCALE), i.e. 25 cycles at defaults.
- Arbitration is sampled only at frame start, so AS/GT changes mid-frame have no effect until the next frame:
  - AS=1, GT=0: A.
  - AS=0, GT=1: G.
  - Both 0: ZERO.
  - Both 1: the grant alternates vs last_grant. After reset the first tie gives A.
  - last_grant updates only on A or G grants; ZERO leaves it unchanged.
- EN=0 in any state: next edge goes to IDLE with C=0, L=0, col=0, cnt=0. SYM holds its value. No FRAME_DONE pulse.
- EN re-asserted: a fresh frame starts from column 0.
- Glyph columns (L hex, columns 1..5):
  - ZERO: 3E 51 49 45 3E.
  - A: 7E 11 11 11 7E.
  - G: 3E 41 49 49 7A.
- SYM code 3 is illegal. If it ever occurs, the ROM returns 00.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronously), with no glitch to a lit column.

Decomposition:
- Shared package matrix_pkg holds:
  - symbol enum sym_t (ZERO/A/G).
  - state enum scan_st_t (IDLE/BLANK/SHOW).
  - NUM_COLS=5, NUM_ROWS=7.
  - glyph constant table.
- One sub-module, matrix_glyph_rom: pure combinational, inputs (sym, col[2:0]), output rows[6:0]. The controller registers its output.

Test Plan:
- Reset then EN=1, AS=GT=0, defaults:
  - Cycle 1 after EN: C=00000, L=00.
  - Cycles 2-5: C=00001, L=3E.
  - Columns repeat every 5 cycles.
  - FRAME_DONE pulses once at cycle 25; SYM=0.
- AS=1, GT=0 held: column 2 shows L=11, column 5 shows L=7E. AS dropped mid-frame keeps SYM=A until that frame's FRAME_DONE, then the next frame is ZERO.
- AS=GT=1 held for 3 frames: SYM sequence is A, G, A. After an intervening ZERO frame, the next tie gives G (last_grant retained).
- BLANK_CYC=0, PRESCALE=1: C sequence 00001, 00010, 00100, 01000, 10000, 00001 on consecutive cycles; FRAME_DONE every 5 cycles.
- EN=0 during column 3 SHOW: next cycle C=0, L=0, no FRAME_DONE. EN=1 restarts at column 1 after BLANK.
- RST_N pulsed low mid-SHOW (asynchronous, between edges): C and L go to 0 before the next edge. The first tie after release grants A.
